// File: rtl/cdb_broadcast.sv
// cdb_broadcast: collects FU results into per-FU FIFOs and broadcasts up to
// WIDTH of them per cycle on the CDB, round-robin across FUs.

// Per-FU result FIFO; head is always visible, pop/push may coincide.
module cdb_fu_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 38,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_head,
  output logic [CW-1:0] o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  // storage write; data needs no reset, validity lives in r_count
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_tail] <= i_din;
  end

  // pointers and occupancy; flush empties the queue
  always_ff @(posedge clock) begin
    if (!reset_n || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
      if (i_pop)  r_head <= (r_head == PW'(DEPTH - 1)) ? '0 : r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module cdb_broadcast #(
  parameter int WIDTH     = 2,
  parameter int NUM_FU    = 4,
  parameter int BUF_DEPTH = 2,
  parameter int PRF_SIZE  = 64,
  parameter int PRF_IDX   = $clog2(PRF_SIZE),
  parameter int XLEN      = 32
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            squash,
  input  logic [NUM_FU-1:0]               fu_valid,
  input  logic [NUM_FU-1:0][PRF_IDX-1:0]  fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]     fu_val,
  output logic [NUM_FU-1:0]               fu_ready,
  output logic [WIDTH-1:0][PRF_IDX:0]     cdb,
  output logic [WIDTH-1:0][XLEN-1:0]      val
);
  localparam int DW  = PRF_IDX + XLEN;
  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int FUW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0][DW-1:0] w_head;
  logic [NUM_FU-1:0][CW-1:0] w_cnt;
  logic [NUM_FU-1:0]         w_nempty, w_grant, w_push, w_pop;
  logic [WIDTH-1:0]          w_lane_vld;
  logic [WIDTH-1:0][DW-1:0]  w_lane_d;
  logic [FUW-1:0]            r_rr, w_rr_nxt;
  int                        w_pos  [NUM_FU];
  int                        w_rank [NUM_FU];
  int                        w_last, w_last_pos;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign w_nempty[i] = (w_cnt[i] != '0);
    // ready from registered count only; a same-cycle pop does not free a slot
    assign fu_ready[i] = reset_n && (w_cnt[i] < CW'(BUF_DEPTH));
    assign w_push[i]   = fu_valid[i] && fu_ready[i] && !squash;
    assign w_pop[i]    = w_grant[i] && !squash;

    cdb_fu_fifo #(.DEPTH(BUF_DEPTH), .DW(DW), .CW(CW)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .i_flush (squash),
      .i_push  (w_push[i]),
      .i_pop   (w_pop[i]),
      .i_din   ({fu_tag[i], fu_val[i]}),
      .o_head  (w_head[i]),
      .o_count (w_cnt[i])
    );
  end

  // round-robin select: rank each non-empty FU by scan distance from r_rr,
  // the first WIDTH ranks win lanes in order
  always_comb begin
    w_grant    = '0;
    w_lane_vld = '0;
    w_lane_d   = '0;
    w_last     = 0;
    w_last_pos = -1;
    for (int f = 0; f < NUM_FU; f++)
      w_pos[f] = (f + NUM_FU - int'(r_rr)) % NUM_FU;
    for (int f = 0; f < NUM_FU; f++) begin
      w_rank[f] = 0;
      for (int g = 0; g < NUM_FU; g++)
        if (w_nempty[g] && (w_pos[g] < w_pos[f])) w_rank[f] = w_rank[f] + 1;
      w_grant[f] = w_nempty[f] && (w_rank[f] < WIDTH);
      if (w_grant[f] && (w_pos[f] > w_last_pos)) begin
        w_last_pos = w_pos[f];
        w_last     = f;
      end
    end
    for (int k = 0; k < WIDTH; k++)
      for (int f = 0; f < NUM_FU; f++)
        if (w_grant[f] && (w_rank[f] == k)) begin
          w_lane_vld[k] = 1'b1;
          w_lane_d[k]   = w_head[f];
        end
    w_rr_nxt = (w_grant != '0) ? FUW'((w_last + 1) % NUM_FU) : r_rr;
  end

  // registered broadcast lanes and round-robin pointer
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rr <= '0;
      cdb  <= '0;
      val  <= '0;
    end else if (squash) begin
      // in-flight grants are dropped; pointer keeps its position
      cdb <= '0;
      val <= '0;
    end else begin
      r_rr <= w_rr_nxt;
      for (int k = 0; k < WIDTH; k++) begin
        cdb[k] <= {w_lane_vld[k], w_lane_d[k][DW-1 -: PRF_IDX]};
        val[k] <= w_lane_d[k][XLEN-1:0];
      end
    end
  end
endmodule

// File: tb/tb_cdb_broadcast.sv
// Self-checking bench for cdb_broadcast: directed scenarios then random
// traffic, compared against a queue-based reference model.
module tb_cdb_broadcast;
  localparam int W = 2, N = 4, D = 2, PI = 6, XL = 32;

  logic                    clock = 1'b0, reset_n = 1'b0, squash = 1'b0;
  logic [N-1:0]            fu_valid = '0;
  logic [N-1:0][PI-1:0]    fu_tag = '0;
  logic [N-1:0][XL-1:0]    fu_val = '0;
  logic [N-1:0]            fu_ready;
  logic [W-1:0][PI:0]      cdb;
  logic [W-1:0][XL-1:0]    val;

  cdb_broadcast #(.WIDTH(W), .NUM_FU(N), .BUF_DEPTH(D), .PRF_SIZE(64), .XLEN(XL)) dut (
    .clock(clock), .reset_n(reset_n), .squash(squash), .fu_valid(fu_valid),
    .fu_tag(fu_tag), .fu_val(fu_val), .fu_ready(fu_ready), .cdb(cdb), .val(val)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [PI-1:0] t; logic [XL-1:0] v; } ent_t;

  ent_t         q [N][$];    // model FIFO contents
  int           rr = 0;      // model round-robin start
  logic [N-1:0] acc;         // accepted at last edge
  logic         exp_c [W];
  ent_t         exp_l [W];
  logic [N-1:0] hv = '0;     // FU holding a result
  ent_t         he [N];
  logic [PI-1:0] tagc = 6'd32;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // new results for idle FUs in mask
  task automatic gen(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++)
      if (mask[i] && !hv[i]) begin
        hv[i] = 1'b1;
        he[i] = {tagc, 32'($urandom)};
        tagc  = tagc + 1'b1;
      end
  endtask

  // one clock: drive, check ready, advance model, check registered lanes
  task automatic cyc(input bit r, input bit s);
    int n, last, f;
    logic [N-1:0] er;
    reset_n = r; squash = s; fu_valid = hv;
    for (int i = 0; i < N; i++) begin fu_tag[i] = he[i].t; fu_val[i] = he[i].v; end
    #1;
    for (int i = 0; i < N; i++) er[i] = r && (q[i].size() < D);
    chk("fu_ready", 64'(fu_ready), 64'(er));
    for (int k = 0; k < W; k++) begin exp_c[k] = 1'b0; exp_l[k] = '0; end
    acc = '0;
    if (!r) begin
      for (int i = 0; i < N; i++) q[i].delete();
      rr = 0;
    end else if (s) begin
      for (int i = 0; i < N; i++) q[i].delete();
    end else begin
      for (int i = 0; i < N; i++) acc[i] = hv[i] && er[i];
      n = 0; last = -1;
      for (int j = 0; j < N; j++) begin
        f = (rr + j) % N;
        if (q[f].size() > 0 && n < W) begin
          exp_c[n] = 1'b1; exp_l[n] = q[f].pop_front(); n++; last = f;
        end
      end
      if (last >= 0) rr = (last + 1) % N;
      for (int i = 0; i < N; i++) if (acc[i]) q[i].push_back(he[i]);
    end
    @(posedge clock); @(negedge clock);
    for (int k = 0; k < W; k++)
      chk($sformatf("lane%0d", k), 64'({cdb[k], val[k]}), 64'({exp_c[k], exp_l[k]}));
    for (int i = 0; i < N; i++) if (acc[i]) hv[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PI-1:0] got [$];
    int bpi, bud;
    for (int i = 0; i < N; i++) he[i] = '0;

    // 1 reset with all FUs valid
    gen(4'hF);
    cyc(0, 0); cyc(0, 0);
    chk("rst_cdb", 64'(cdb), 64'd0);
    chk("rst_val", 64'(val), 64'd0);
    hv = '0;
    cyc(1, 0);
    chk("rel_ready", 64'(fu_ready), 64'hF);

    // 2 single result from FU2, then rr_ptr=3 check via FU0/FU3 race
    hv[2] = 1'b1; he[2] = {6'd5, 32'hDEAD};
    cyc(1, 0); cyc(1, 0);
    chk("single_cdb0", 64'(cdb[0]), 64'({1'b1, 6'd5}));
    chk("single_val0", 64'(val[0]), 64'h0000DEAD);
    chk("single_l1", 64'(cdb[1][PI]), 64'd0);
    hv[0] = 1'b1; he[0] = {6'd20, 32'h20};
    hv[3] = 1'b1; he[3] = {6'd21, 32'h21};
    cyc(1, 0); cyc(1, 0);
    chk("rr3_lane0", 64'(cdb[0]), 64'({1'b1, 6'd21}));
    chk("rr3_lane1", 64'(cdb[1]), 64'({1'b1, 6'd20}));

    // 3 fairness, all FUs busy
    for (int c = 0; c < 8; c++) begin gen(4'hF); cyc(1, 0); end

    // 4 back-pressure on FU1 with tags 7,8,9
    bpi = 0; bud = 0;
    while (got.size() < 3 && bud < 30) begin
      if (!hv[1] && bpi < 3) begin
        hv[1] = 1'b1; he[1] = {6'(7 + bpi), 32'($urandom)}; bpi++;
      end
      gen(4'b1101);
      cyc(1, 0);
      for (int k = 0; k < W; k++)
        if (cdb[k][PI] && cdb[k][PI-1:0] >= 6'd7 && cdb[k][PI-1:0] <= 6'd9) got.push_back(cdb[k][PI-1:0]);
      bud++;
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("bp_order", 64'((i < got.size()) ? got[i] : 6'h3F), 64'(7 + i));

    // 5 squash with FIFOs loaded, FU0 offering tag 12
    for (int c = 0; c < 3; c++) begin gen(4'hF); cyc(1, 0); end
    hv[0] = 1'b1; he[0] = {6'd12, 32'h12};
    cyc(1, 1);
    chk("sq_c0", 64'(cdb[0][PI]), 64'd0);
    chk("sq_c1", 64'(cdb[1][PI]), 64'd0);
    hv = '0;
    cyc(1, 0);
    chk("sq_ready", 64'(fu_ready), 64'hF);
    for (int c = 0; c < 3; c++) cyc(1, 0);

    // 6 reset mid-operation, then rr restart at FU0
    for (int c = 0; c < 3; c++) begin gen(4'hF); cyc(1, 0); end
    cyc(0, 0);
    hv = '0;
    chk("mid_rst_cdb", 64'(cdb), 64'd0);
    hv[0] = 1'b1; he[0] = {6'd40, 32'h40};
    hv[3] = 1'b1; he[3] = {6'd43, 32'h43};
    cyc(1, 0); cyc(1, 0);
    chk("mid_rr0", 64'(cdb[0]), 64'({1'b1, 6'd40}));

    // 7 random traffic with occasional squash/reset
    for (int c = 0; c < 400; c++) begin
      bit r, s;
      r = ($urandom_range(0, 49) != 0);
      s = ($urandom_range(0, 29) == 0);
      gen(4'($urandom));
      cyc(r, s);
      if (!r || s) hv = '0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
